// File: rtl/tdc_stream_tx.sv
// tdc_stream_tx: latches one TDC snapshot per laser shot and streams it
// to the histogram builder one pixel word per clock, ACQ_NUM shots/frame.
module tdc_stream_tx #(
    parameter int NP = 10,
    parameter int PIXEL_NUM = 6,
    parameter int ACQ_NUM = 2,
    parameter logic [NP-1:0] NO_HIT_CODE = {NP{1'b1}},
    localparam int PW = (PIXEL_NUM > 1) ? $clog2(PIXEL_NUM) : 1,
    localparam int AW = (ACQ_NUM > 1) ? $clog2(ACQ_NUM) : 1
) (
    input  logic                    clk,
    input  logic                    res,
    input  logic                    start,
    input  logic                    acq_strobe,
    input  logic [PIXEL_NUM-1:0]    tdc_hit,
    input  logic [PIXEL_NUM*NP-1:0] tdc_time,
    output logic                    wrEn,
    output logic [NP-1:0]           data,
    output logic [PW-1:0]           pix_idx,
    output logic [AW-1:0]           acq_idx,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    overrun
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACQ,
        SHIFT,
        DONE
    } state_t;

    localparam logic [PW-1:0] LAST_PIX = PW'(PIXEL_NUM - 1);
    localparam logic [AW-1:0] LAST_ACQ = AW'(ACQ_NUM - 1);

    state_t              state;
    logic [PW-1:0]       pixCnt;
    logic [AW-1:0]       acqCnt;
    logic [PIXEL_NUM-1:0] shHit;
    logic [NP-1:0]       shTime [PIXEL_NUM];

    logic [NP-1:0] curTime;
    logic          curHit;
    logic [NP-1:0] word;

    // A real hit stamped with the reserved code is pulled down by one
    // so NO_HIT_CODE always means "no hit" downstream.
    always_comb begin
        curTime = shTime[pixCnt];
        curHit  = shHit[pixCnt];
        unique case (1'b1)
            curHit && (curTime == NO_HIT_CODE): word = NO_HIT_CODE - NP'(1);
            curHit && (curTime != NO_HIT_CODE): word = curTime;
            default:                            word = NO_HIT_CODE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state      <= IDLE;
            pixCnt     <= '0;
            acqCnt     <= '0;
            shHit      <= '0;
            for (int k = 0; k < PIXEL_NUM; k++) begin
                shTime[k] <= '0;
            end
            wrEn       <= 1'b0;
            data       <= '0;
            pix_idx    <= '0;
            acq_idx    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            wrEn       <= 1'b0;
            frame_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    busy <= start;
                    if (start) begin
                        acqCnt  <= '0;
                        overrun <= 1'b0;
                        state   <= WAIT_ACQ;
                    end
                end
                WAIT_ACQ: begin
                    if (acq_strobe) begin
                        shHit  <= tdc_hit;
                        for (int k = 0; k < PIXEL_NUM; k++) begin
                            shTime[k] <= tdc_time[k*NP +: NP];
                        end
                        pixCnt <= '0;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    wrEn    <= 1'b1;
                    data    <= word;
                    pix_idx <= pixCnt;
                    acq_idx <= acqCnt;
                    if (acq_strobe) begin
                        overrun <= 1'b1;
                    end
                    if (pixCnt == LAST_PIX) begin
                        pixCnt <= '0;
                        if (acqCnt == LAST_ACQ) begin
                            state <= DONE;
                        end else begin
                            acqCnt <= acqCnt + AW'(1);
                            state  <= WAIT_ACQ;
                        end
                    end else begin
                        pixCnt <= pixCnt + PW'(1);
                    end
                end
                DONE: begin
                    // busy is held through the frame_done cycle
                    frame_done <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tdc_stream_tx.sv
// tb_tdc_stream_tx: table vectors, corner sequences and a random run,
// all checked every cycle against a shot/timeline reference model.
module tb_tdc_stream_tx;

    localparam int NP = 10;
    localparam int PIX = 6;
    localparam int ACQ = 2;
    localparam int NO_HIT = 1023;

    logic             clk;
    logic             res;
    logic             start;
    logic             acq_strobe;
    logic [PIX-1:0]   tdc_hit;
    logic [PIX*NP-1:0] tdc_time;
    logic             wrEn;
    logic [NP-1:0]    data;
    logic [2:0]       pix_idx;
    logic [0:0]       acq_idx;
    logic             busy;
    logic             frame_done;
    logic             overrun;

    tdc_stream_tx dut (
        .clk        (clk),
        .res        (res),
        .start      (start),
        .acq_strobe (acq_strobe),
        .tdc_hit    (tdc_hit),
        .tdc_time   (tdc_time),
        .wrEn       (wrEn),
        .data       (data),
        .pix_idx    (pix_idx),
        .acq_idx    (acq_idx),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [PIX-1:0] hit;
        int             t [PIX];
        int             e [PIX];
    } vec_t;

    typedef struct {
        int due;
        int d;
        int pix;
        int acq;
    } word_t;

    vec_t  vecs [4];
    word_t expQ [$];
    int    capData [$];
    int    capPix [$];
    int    capAcq [$];

    int nCmp = 0;
    int nErr = 0;
    int cyc = 0;
    bit mActive = 0;
    int mShots = 0;
    int mShiftLast = -1;
    int mDoneEdge = -1;
    bit mOverrun = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d",
                     nm, cyc, act, exp);
        end
    endtask

    function automatic int refWord(input logic h, input int t);
        if (!h) return NO_HIT;
        if (t == NO_HIT) return NO_HIT - 1;
        return t;
    endfunction

    // Reference: a frame opens on start, takes ACQ shots; each accepted
    // shot yields PIX words due on the PIX edges that follow it.
    task automatic modelEdge();
        if (res) begin
            mActive = 0;
            mOverrun = 0;
            mShiftLast = -1;
            mDoneEdge = -1;
            expQ.delete();
            return;
        end
        if (mActive && mDoneEdge >= 0 && cyc > mDoneEdge) mActive = 0;
        if (!mActive) begin
            if (start) begin
                mActive = 1;
                mShots = 0;
                mOverrun = 0;
                mDoneEdge = -1;
            end
        end else if (cyc <= mShiftLast) begin
            if (acq_strobe) mOverrun = 1;
        end else if (mShots < ACQ && acq_strobe) begin
            for (int k = 0; k < PIX; k++) begin
                word_t w;
                w.due = cyc + 1 + k;
                w.d = refWord(tdc_hit[k], int'(tdc_time[k*NP +: NP]));
                w.pix = k;
                w.acq = mShots;
                expQ.push_back(w);
            end
            mShots++;
            mShiftLast = cyc + PIX;
            if (mShots == ACQ) mDoneEdge = cyc + PIX + 1;
        end
    endtask

    task automatic compareAll();
        word_t w;
        bit expWr;
        expWr = (expQ.size() > 0) && (expQ[0].due == cyc);
        chk("wrEn", wrEn, expWr);
        if (expWr) begin
            w = expQ.pop_front();
            chk("data", data, w.d);
            chk("pix_idx", pix_idx, w.pix);
            chk("acq_idx", acq_idx, w.acq);
        end
        chk("busy", busy, mActive);
        chk("frame_done", frame_done, mDoneEdge >= 0 && cyc == mDoneEdge);
        chk("overrun", overrun, mOverrun);
        if (wrEn === 1'b1) begin
            capData.push_back(int'(data));
            capPix.push_back(int'(pix_idx));
            capAcq.push_back(int'(acq_idx));
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        modelEdge();
        #1;
        compareAll();
        start = 1'b0;
        acq_strobe = 1'b0;
    endtask

    task automatic capClr();
        capData.delete();
        capPix.delete();
        capAcq.delete();
    endtask

    task automatic fire(input int vi);
        tdc_hit = vecs[vi].hit;
        for (int k = 0; k < PIX; k++) begin
            tdc_time[k*NP +: NP] = NP'(vecs[vi].t[k]);
        end
        acq_strobe = 1'b1;
        step();
    endtask

    task automatic checkShot(input int vi, input int acq);
        chk("shot_words", capData.size(), PIX);
        for (int k = 0; k < PIX && k < capData.size(); k++) begin
            chk("shot_data", capData[k], vecs[vi].e[k]);
            chk("shot_pix", capPix[k], k);
            chk("shot_acq", capAcq[k], acq);
        end
    endtask

    initial begin
        res = 1'b1;
        start = 1'b0;
        acq_strobe = 1'b0;
        tdc_hit = '0;
        tdc_time = '0;
        vecs[0] = '{6'h3f, '{108, 511, 1022, 200, 90, 300},
                           '{108, 511, 1022, 200, 90, 300}};
        vecs[1] = '{6'h3f, '{300, 500, 50, 1000, 48, 90},
                           '{300, 500, 50, 1000, 48, 90}};
        vecs[2] = '{6'b000101, '{1023, 1023, 1023, 1023, 1023, 1023},
                               '{1022, 1023, 1022, 1023, 1023, 1023}};
        vecs[3] = '{6'b101010, '{1, 2, 3, 1023, 5, 0},
                               '{1023, 2, 1023, 1022, 1023, 0}};

        step();
        step();
        chk("rst_wrEn", wrEn, 0);
        chk("rst_data", data, 0);
        chk("rst_pix", pix_idx, 0);
        chk("rst_acq", acq_idx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_ovr", overrun, 0);
        res = 1'b0;
        step();

        // table: two frames, two shots each
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) begin
                start = 1'b1;
                step();
            end
            capClr();
            fire(i);
            repeat (PIX) step();
            checkShot(i, i % 2);
            step();
            chk("gap_wrEn", wrEn, 0);
            if (i % 2 == 1) begin
                chk("tbl_done", frame_done, 1);
                chk("tbl_busy_hi", busy, 1);
                step();
                chk("tbl_done_lo", frame_done, 0);
                chk("tbl_busy_lo", busy, 0);
            end
        end

        // overrun: second strobe three cycles after the first
        start = 1'b1;
        step();
        capClr();
        fire(0);
        step();
        step();
        fire(1);
        repeat (3) step();
        checkShot(0, 0);
        chk("ovr_set", overrun, 1);
        capClr();
        repeat (4) step();
        chk("ovr_nowords", capData.size(), 0);
        fire(2);
        repeat (PIX) step();
        checkShot(2, 1);
        step();
        chk("ovr_done", frame_done, 1);
        chk("ovr_sticky", overrun, 1);
        step();
        step();
        start = 1'b1;
        step();
        chk("ovr_clr", overrun, 0);

        // reset during the third word
        fire(3);
        step();
        step();
        step();
        chk("mid_wr3", wrEn, 1);
        res = 1'b1;
        step();
        res = 1'b0;
        chk("mid_wrEn", wrEn, 0);
        chk("mid_data", data, 0);
        chk("mid_pix", pix_idx, 0);
        chk("mid_acq", acq_idx, 0);
        chk("mid_busy", busy, 0);
        chk("mid_ovr", overrun, 0);
        capClr();
        fire(0);
        repeat (10) step();
        chk("mid_nowords", capData.size(), 0);

        // start ignored in WAIT_ACQ and SHIFT
        start = 1'b1;
        step();
        start = 1'b1;
        step();
        capClr();
        fire(1);
        step();
        start = 1'b1;
        step();
        repeat (4) step();
        checkShot(1, 0);
        step();
        capClr();
        start = 1'b1;
        fire(3);
        repeat (PIX) step();
        checkShot(3, 1);
        step();
        chk("ign_done", frame_done, 1);
        step();
        capClr();
        fire(0);
        repeat (3) step();
        chk("idle_nowords", capData.size(), 0);
        chk("idle_ovr", overrun, 0);

        // back-to-back frames
        start = 1'b1;
        step();
        fire(0);
        repeat (PIX) step();
        step();
        fire(1);
        repeat (PIX) step();
        step();
        chk("b2b_done", frame_done, 1);
        start = 1'b1;
        step();
        chk("b2b_busy", busy, 1);
        capClr();
        fire(2);
        repeat (PIX) step();
        checkShot(2, 0);

        // random traffic against the model
        repeat (3000) begin
            res = ($urandom_range(0, 299) == 0);
            start = ($urandom_range(0, 15) == 0);
            acq_strobe = ($urandom_range(0, 3) == 0);
            tdc_hit = PIX'($urandom);
            for (int k = 0; k < PIX; k++) begin
                if ($urandom_range(0, 7) == 0)
                    tdc_time[k*NP +: NP] = NP'(NO_HIT);
                else
                    tdc_time[k*NP +: NP] = NP'($urandom_range(0, 1023));
            end
            step();
        end
        res = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 nCmp, nErr);
        $finish;
    end

endmodule

// File: doc/tdc_stream_tx.md
Name: tdc_stream_tx

Overview:
- Transmitter side of the histogram-builder input stream.
- Captures one parallel snapshot of per-pixel TDC timestamps per laser shot.
- Serialises the snapshot as one word per clock, in pixel order, on the data/wrEn interface that hisBuilderFSM consumes.
- Counts ACQ_NUM shots per frame and flags frame completion and dropped shots.

Parameters:
- NP, 10: timestamp width in bits (matches `Np).
- PIXEL_NUM, 6: pixels per snapshot; words emitted per shot.
- ACQ_NUM, 2: shots (acquisitions) per frame.
- NO_HIT_CODE, {NP{1'b1}}: reserved data word for a pixel with no hit.

Ports:
- clk  in  1  system clock
- res  in  1  synchronous reset, active-high
- start  in  1  single-cycle pulse; begins a frame
- acq_strobe  in  1  single-cycle pulse; TDC snapshot valid for this shot
- tdc_hit  in  PIXEL_NUM  per-pixel hit flag, sampled with acq_strobe
- tdc_time  in  PIXEL_NUM*NP  packed timestamps; pixel k is at [k*NP +: NP]
- wrEn  out  1  word valid to histogram builder
- data  out  NP  timestamp word
- pix_idx  out  clog2(PIXEL_NUM)  pixel index of the current word
- acq_idx  out  clog2(ACQ_NUM) (min 1)  shot index of the current word
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse after the last word of the frame
- overrun  out  1  sticky; an acq_strobe was dropped

Behaviour:
- All outputs are registered.
- Reset values: wrEn=0, data=0, pix_idx=0, acq_idx=0, busy=0, frame_done=0, overrun=0. FSM state = IDLE. Shadow registers = 0.
- res has priority over all other inputs. Asserting res mid-frame:
  - aborts the frame;
  - from the first edge with res high, wrEn=0 and no further words are emitted;
  - no frame_done pulse is produced.
- FSM states: IDLE, WAIT_ACQ, SHIFT, DONE.
- IDLE:
  - on start: acq_cnt=0, overrun cleared, go to WAIT_ACQ.
  - acq_strobe is ignored and does not set overrun.
- WAIT_ACQ:
  - on acq_strobe: latch tdc_hit and tdc_time into shadow registers, pix_cnt=0, go to SHIFT.
  - start is ignored in this state.
- SHIFT:
  - emits one word per cycle, pixels 0..PIXEL_NUM-1, with no gaps.
  - word for pixel k:
    - hit=1: data = time; if time == NO_HIT_CODE, clamp to NO_HIT_CODE-1 so the reserved code stays unique.
    - hit=0: data = NO_HIT_CODE.
  - wrEn=1 with pix_idx=k and acq_idx=acq_cnt.
- Latency: acq_strobe sampled at edge T gives pixel 0 visible after edge T+1 and pixel k after edge T+1+k. wrEn stays high for exactly PIXEL_NUM consecutive cycles.
- After the pixel PIXEL_NUM-1 word:
  - if acq_cnt == ACQ_NUM-1: go to DONE;
  - else: acq_cnt+1, go to WAIT_ACQ.
  - wrEn returns to 0 in the cycle after the last word.
- acq_strobe during SHIFT, including the last SHIFT cycle: the strobe is dropped, shadow registers are unchanged, and overrun is set. overrun stays set until the next accepted start or res.
- DONE: frame_done=1 for exactly one cycle, then go to IDLE. busy falls together with the frame_done pulse cycle ending (busy=0 in IDLE).
- start while not in IDLE: ignored, no effect on counters.
- Simultaneous start and acq_strobe in IDLE: start is taken, strobe is ignored. The first shot requires a later strobe.
- Counters wrap only by FSM control. pix_cnt and acq_cnt never exceed PIXEL_NUM-1 and ACQ_NUM-1.
- No backpressure: the downstream builder accepts one word per clock unconditionally.

Test Plan:
- Basic frame (defaults: NP=10, PIXEL_NUM=6, ACQ_NUM=2):
  - Stimulus: res, then start; acq_strobe with all hits, times 108,511,1022,200,90,300.
  - Required: six consecutive wrEn cycles beginning 1 cycle after the strobe, data in that order, pix_idx 0..5, acq_idx=0.
  - Stimulus: a second strobe with times 300,500,50,1000,48,90.
  - Required: six words with acq_idx=1, then frame_done for 1 cycle, busy=0.
- No-hit and clamp:
  - Stimulus: tdc_hit=6'b000101, all times 1023.
  - Required: data = 1022,1023,1022,1023,1023,1023.
- Overrun:
  - Stimulus: a second acq_strobe 3 cycles after the first.
  - Required: the first shot's six words are unchanged, overrun=1, FSM waits for a new strobe for acq_idx=1.
  - Stimulus: a subsequent start.
  - Required: overrun clears.
- Reset mid-SHIFT:
  - Stimulus: res asserted during the 3rd word.
  - Required: wrEn=0 from that edge, all outputs at reset values, no frame_done.
  - Stimulus: strobe with no start.
  - Required: no words emitted.
- Ignored controls:
  - Stimulus: start during WAIT_ACQ or SHIFT.
  - Required: acq_idx sequence is not reset.
  - Stimulus: acq_strobe in IDLE.
  - Required: wrEn stays 0 and overrun stays 0.
- Back-to-back frames:
  - Stimulus: start asserted in the cycle right after frame_done.
  - Required: the new frame accepts the next strobe, acq_idx restarts at 0.
